// File: rtl/weight_stream_loader.sv
// weight_stream_loader: unpacks AXI-Stream weight beats (PACK words per beat)
// into one-word-per-cycle writes, steering each word to the kernel, bias or
// MAC-coefficient region. One load runs per accepted load_start; tlast
// framing is checked against the configured word total.
module weight_stream_loader #(
  parameter int DATA_W       = 32,
  parameter int PACK         = 1,
  parameter int KERNEL_COUNT = 72,
  parameter int BIAS_COUNT   = 4,
  parameter int COEFF_COUNT  = 1,
  parameter int ADDR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [DATA_W*PACK-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic                   weight_wr_en,
  output logic [DATA_W-1:0]      weight_wr_data,
  output logic [1:0]             weight_wr_sel,
  output logic [ADDR_W-1:0]      weight_wr_addr,
  output logic [ADDR_W-1:0]      weight_wr_gaddr,
  output logic                   load_busy,
  output logic                   load_done,
  output logic [1:0]             load_err,
  output logic [ADDR_W-1:0]      words_loaded
);

  localparam int S_W    = DATA_W * PACK;
  localparam int TOTAL  = KERNEL_COUNT + BIAS_COUNT + COEFF_COUNT;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [ADDR_W-1:0] LAST_G    = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] K_BASE    = ADDR_W'(KERNEL_COUNT);
  localparam logic [ADDR_W-1:0] KB_BASE   = ADDR_W'(KERNEL_COUNT + BIAS_COUNT);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    UNPACK = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [LANE_W-1:0]  lane_reg, lane_next;
  logic [S_W-1:0]     beat_reg;
  logic               beat_last_reg;
  logic [ADDR_W-1:0]  g_reg;
  logic               wr_en_reg;
  logic [DATA_W-1:0]  wr_data_reg;
  logic [1:0]         wr_sel_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [ADDR_W-1:0]  wr_gaddr_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [1:0]         err_reg;
  logic [ADDR_W-1:0]  words_reg;

  logic               start_ok;
  logic               emit;
  logic [DATA_W-1:0]  emit_data;
  logic               emit_last;
  logic [LANE_W-1:0]  cur_lane;
  logic [1:0]         err_set;
  logic [1:0]         sel_c;
  logic [ADDR_W-1:0]  addr_c;

  // Lane view of the latched beat; lane 0 sits in the least significant bits.
  logic [DATA_W-1:0] beat_words [PACK];
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign beat_words[gi] = beat_reg[gi*DATA_W +: DATA_W];
  end

  // Ready depends on state only, never on tvalid.
  assign s_axis_tready = (state_reg == RECV) || (state_reg == FLUSH);

  // Region decode of the global word index.
  always_comb begin
    sel_c  = 2'd0;
    addr_c = g_reg;
    if (g_reg < K_BASE) begin
      sel_c  = 2'd0;
      addr_c = g_reg;
    end else if (g_reg < KB_BASE) begin
      sel_c  = 2'd1;
      addr_c = g_reg - K_BASE;
    end else begin
      sel_c  = 2'd2;
      addr_c = g_reg - KB_BASE;
    end
  end

  // Next-state logic: word emission, lane stepping and framing checks.
  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    start_ok   = 1'b0;
    emit       = 1'b0;
    emit_data  = s_axis_tdata[DATA_W-1:0];
    emit_last  = s_axis_tlast;
    cur_lane   = '0;
    err_set    = 2'b00;
    case (state_reg)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (load_start && !done_reg) begin
          start_ok   = 1'b1;
          state_next = RECV;
          lane_next  = '0;
        end
      end
      RECV: begin
        if (s_axis_tvalid) begin
          emit = 1'b1;
        end
      end
      UNPACK: begin
        emit      = 1'b1;
        cur_lane  = lane_reg;
        emit_data = beat_words[lane_reg];
        emit_last = beat_last_reg;
      end
      FLUSH: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (emit) begin
      if (g_reg == LAST_G) begin
        // Final word: any remaining lanes are dropped.
        lane_next  = '0;
        state_next = emit_last ? DONE : FLUSH;
        err_set[1] = ~emit_last;
      end else if (cur_lane == LAST_LANE) begin
        lane_next = '0;
        if (emit_last) begin
          state_next = DONE;
          err_set[0] = 1'b1;
        end else begin
          state_next = RECV;
        end
      end else begin
        lane_next  = cur_lane + LANE_W'(1);
        state_next = UNPACK;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lane_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
    end
  end

  // Datapath: beat latch, write port, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg      <= '0;
      beat_last_reg <= 1'b0;
      g_reg         <= '0;
      wr_en_reg     <= 1'b0;
      wr_data_reg   <= '0;
      wr_sel_reg    <= 2'd0;
      wr_addr_reg   <= '0;
      wr_gaddr_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 2'b00;
      words_reg     <= '0;
    end else begin
      wr_en_reg <= emit;
      done_reg  <= (state_reg == DONE);
      err_reg   <= err_reg | err_set;
      if (state_reg == DONE) begin
        busy_reg <= 1'b0;
      end
      if (start_ok) begin
        g_reg     <= '0;
        words_reg <= '0;
        err_reg   <= 2'b00;
        busy_reg  <= 1'b1;
      end
      if (state_reg == RECV && s_axis_tvalid) begin
        beat_reg      <= s_axis_tdata;
        beat_last_reg <= s_axis_tlast;
      end
      if (emit) begin
        wr_data_reg  <= emit_data;
        wr_sel_reg   <= sel_c;
        wr_addr_reg  <= addr_c;
        wr_gaddr_reg <= g_reg;
        words_reg    <= g_reg + ADDR_W'(1);
        if (g_reg != LAST_G) begin
          g_reg <= g_reg + ADDR_W'(1);
        end
      end
    end
  end

  assign weight_wr_en    = wr_en_reg;
  assign weight_wr_data  = wr_data_reg;
  assign weight_wr_sel   = wr_sel_reg;
  assign weight_wr_addr  = wr_addr_reg;
  assign weight_wr_gaddr = wr_gaddr_reg;
  assign load_busy       = busy_reg;
  assign load_done       = done_reg;
  assign load_err        = err_reg;
  assign words_loaded    = words_reg;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Bench for weight_stream_loader: one PACK=1 and one PACK=2 instance share
// the stimulus; a mode variable selects which one is driven and observed.
module tb_weight_stream_loader;

  localparam int TOTAL = 77;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [63:0] tdata = '0;
  int          mode = 0;

  always #5 clk = ~clk;

  logic        start1, start2;
  logic        rdy1, en1, busy1, done1;
  logic [31:0] data1;
  logic [1:0]  sel1, err1;
  logic [15:0] addr1, gaddr1, wl1;
  logic        rdy2, en2, busy2, done2;
  logic [31:0] data2;
  logic [1:0]  sel2, err2;
  logic [15:0] addr2, gaddr2, wl2;

  assign start1 = start && (mode == 0);
  assign start2 = start && (mode == 1);

  weight_stream_loader #(.PACK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(start1),
    .s_axis_tdata(tdata[31:0]), .s_axis_tvalid(tvalid && mode == 0),
    .s_axis_tready(rdy1), .s_axis_tlast(tlast),
    .weight_wr_en(en1), .weight_wr_data(data1), .weight_wr_sel(sel1),
    .weight_wr_addr(addr1), .weight_wr_gaddr(gaddr1),
    .load_busy(busy1), .load_done(done1), .load_err(err1), .words_loaded(wl1)
  );

  weight_stream_loader #(.PACK(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_start(start2),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid && mode == 1),
    .s_axis_tready(rdy2), .s_axis_tlast(tlast),
    .weight_wr_en(en2), .weight_wr_data(data2), .weight_wr_sel(sel2),
    .weight_wr_addr(addr2), .weight_wr_gaddr(gaddr2),
    .load_busy(busy2), .load_done(done2), .load_err(err2), .words_loaded(wl2)
  );

  logic        rdy, en, busy, done;
  logic [31:0] data;
  logic [1:0]  sel, err;
  logic [15:0] addr, gaddr, wl;
  assign rdy   = (mode == 0) ? rdy1   : rdy2;
  assign en    = (mode == 0) ? en1    : en2;
  assign busy  = (mode == 0) ? busy1  : busy2;
  assign done  = (mode == 0) ? done1  : done2;
  assign data  = (mode == 0) ? data1  : data2;
  assign sel   = (mode == 0) ? sel1   : sel2;
  assign err   = (mode == 0) ? err1   : err2;
  assign addr  = (mode == 0) ? addr1  : addr2;
  assign gaddr = (mode == 0) ? gaddr1 : gaddr2;
  assign wl    = (mode == 0) ? wl1    : wl2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: flat word list, region map from the word index.
  typedef struct {
    logic [31:0] d;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] gaddr;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wdat [0:255];

  function automatic wr_t mk(input int k, input logic [31:0] d);
    wr_t w;
    w.d = d;
    w.gaddr = 16'(k);
    if (k < 72) begin
      w.sel = 2'd0; w.addr = 16'(k);
    end else if (k < 76) begin
      w.sel = 2'd1; w.addr = 16'(k - 72);
    end else begin
      w.sel = 2'd2; w.addr = 16'(k - 76);
    end
    return w;
  endfunction

  task automatic build_model(input int pk, input int nbeats, input int tl);
    int n;
    exp_q.delete();
    for (int k = 0; k < nbeats * pk; k++) wdat[k] = $urandom;
    n = (tl + 1) * pk;
    if (n > TOTAL) n = TOTAL;
    for (int k = 0; k < n; k++) exp_q.push_back(mk(k, wdat[k]));
  endtask

  // Write monitor, sampled on the falling edge.
  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0, first_wr = 0, last_wr = 0, done_cyc = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (en) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write: got gaddr %0d expected no write", gaddr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (data !== e.d || sel !== e.sel || addr !== e.addr || gaddr !== e.gaddr) begin
            errors++;
            $display("FAIL write: got d=%h sel=%0d addr=%0d g=%0d expected d=%h sel=%0d addr=%0d g=%0d",
                     data, sel, addr, gaddr, e.d, e.sel, e.addr, e.gaddr);
          end
        end
        $display("write g=%0d sel=%0d addr=%0d data=%h", gaddr, sel, addr, data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  typedef struct {
    int         pk;
    int         nbeats;
    int         tl;
    bit         gaps;
    bit         spam;
    bit         contig;
    int         exp_n;
    logic [1:0] exp_err;
  } scen_t;

  scen_t tbl [9];

  task automatic drive_beat(input int pk, input int b, input int tl);
    if (pk == 1) tdata = {32'h0, wdat[b]};
    else         tdata = {wdat[2*b+1], wdat[2*b]};
    tlast  = (b == tl);
    tvalid = 1'b1;
  endtask

  task automatic run_load(input scen_t s);
    int to;
    mode = (s.pk == 1) ? 0 : 1;
    build_model(s.pk, s.nbeats, s.tl);
    wr_cnt = 0; done_cnt = 0;
    mon_on = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", rdy, 1);
    for (int b = 0; b < s.nbeats; b++) begin
      if (s.gaps) begin
        repeat ($urandom % 3) begin
          tvalid = 1'b0;
          start = s.spam && ($urandom % 3 == 0);
          @(negedge clk);
        end
      end
      drive_beat(s.pk, b, s.tl);
      start = s.spam && ($urandom % 3 == 0);
      to = 0;
      while (!rdy && to < 100) begin
        @(negedge clk);
        to++;
        start = s.spam && ($urandom % 3 == 0);
      end
      if (to >= 100) begin
        chk("ready_timeout", 1, 0);
        tvalid = 1'b0; start = 1'b0; mon_on = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0;
    to = 0;
    while (!done && to < 100) begin
      start = s.spam && ($urandom % 2 == 0);
      @(negedge clk);
      to++;
    end
    chk("done_timeout", (to >= 100), 0);
    start = s.spam;              // start during the done cycle must be ignored
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("write_count", wr_cnt, s.exp_n);
    chk("load_err", err, s.exp_err);
    chk("words_loaded", wl, s.exp_n);
    chk("done_pulses", done_cnt, 1);
    chk("busy_end", busy, 0);
    chk("idle_after_done", rdy, 0);
    chk("model_drained", exp_q.size(), 0);
    if (s.contig) chk("contiguous_writes", last_wr - first_wr, s.exp_n - 1);
    if (s.exp_err != 2'b10) chk("done_timing", done_cyc, last_wr + 1);
    $display("load pack=%0d beats=%0d tlast=%0d writes=%0d err=%b", s.pk, s.nbeats, s.tl, wr_cnt, err);
    mon_on = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 77, 76, 1'b0, 1'b0, 1'b1, 77, 2'b00};
    tbl[1] = '{2, 39, 38, 1'b0, 1'b0, 1'b1, 77, 2'b00};
    tbl[2] = '{2, 10,  9, 1'b0, 1'b0, 1'b1, 20, 2'b01};
    tbl[3] = '{1, 80, 79, 1'b0, 1'b0, 1'b1, 77, 2'b10};
    tbl[4] = '{1, 77, 76, 1'b1, 1'b1, 1'b0, 77, 2'b00};
    tbl[5] = '{2, 39, 38, 1'b1, 1'b1, 1'b0, 77, 2'b00};
    tbl[6] = '{2, 45, 44, 1'b1, 1'b0, 1'b0, 77, 2'b10};
    tbl[7] = '{1,  1,  0, 1'b0, 1'b0, 1'b0,  1, 2'b01};
    tbl[8] = '{2, 38, 37, 1'b0, 1'b1, 1'b0, 76, 2'b01};

    // Reset state of both instances.
    #1;
    chk("rst_ready1", rdy1, 0); chk("rst_en1", en1, 0); chk("rst_busy1", busy1, 0);
    chk("rst_err1", err1, 0);   chk("rst_wl1", wl1, 0); chk("rst_data1", data1, 0);
    chk("rst_ready2", rdy2, 0); chk("rst_en2", en2, 0); chk("rst_done2", done2, 0);
    chk("rst_gaddr2", gaddr2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_load(tbl[i]);

    // Reset in the middle of a load, then reload from scratch.
    mode = 0;
    build_model(1, 77, 76);
    wr_cnt = 0; done_cnt = 0; mon_on = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int b = 0; b < 77 && wr_cnt < 30; b++) begin
      int to;
      drive_beat(1, b, 76);
      to = 0;
      while (!rdy && to < 100) begin @(negedge clk); to++; end
      @(negedge clk);
    end
    chk("writes_before_reset", (wr_cnt >= 30), 1);
    rst_n = 1'b0; tvalid = 1'b0;
    #1;
    mon_on = 1'b0;
    chk("midrst_en", en1, 0);     chk("midrst_data", data1, 0);
    chk("midrst_sel", sel1, 0);   chk("midrst_addr", addr1, 0);
    chk("midrst_gaddr", gaddr1, 0); chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0); chk("midrst_err", err1, 0);
    chk("midrst_wl", wl1, 0);     chk("midrst_ready", rdy1, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_load(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
